// File: rtl/imem_fetch_ctrl_if.sv
// Requester-side and ROM-side signals of the instruction fetch sequencer.
// The controller uses the slave modport. Requesters and the ROM use the master modport.
interface imem_fetch_ctrl_if #(
  parameter int ADDRESS_WIDTH        = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int ACTUAL_ADDRESS_WIDTH = 16
);
  logic                            fetch_req_i;
  logic [ADDRESS_WIDTH-1:0]        fetch_addr_i;
  logic                            fetch_rdy_o;
  logic                            fetch_valid_o;
  logic [DATA_WIDTH-1:0]           fetch_data_o;

  logic                            dbg_req_i;
  logic [ADDRESS_WIDTH-1:0]        dbg_addr_i;
  logic                            dbg_rdy_o;
  logic                            dbg_valid_o;
  logic [DATA_WIDTH-1:0]           dbg_data_o;

  logic                            mem_en_o;
  logic [ACTUAL_ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [7:0]                      mem_rd_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i, dbg_req_i, dbg_addr_i, mem_rd_i,
    output fetch_rdy_o, fetch_valid_o, fetch_data_o,
    output dbg_rdy_o, dbg_valid_o, dbg_data_o,
    output mem_en_o, mem_addr_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i, dbg_req_i, dbg_addr_i, mem_rd_i,
    input  fetch_rdy_o, fetch_valid_o, fetch_data_o,
    input  dbg_rdy_o, dbg_valid_o, dbg_data_o,
    input  mem_en_o, mem_addr_o
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Round-robin arbiter and 4-beat byte sequencer in front of the byte-wide instruction ROM.
// Returns one big-endian 32-bit word per accepted request.
module imem_fetch_ctrl #(
  parameter int ADDRESS_WIDTH        = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int ACTUAL_ADDRESS_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [1:0]                      beat;
  logic                            owner_dbg;
  logic                            last_dbg;
  logic [ACTUAL_ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]           word;
  logic [DATA_WIDTH-1:0]           fetch_data;
  logic [DATA_WIDTH-1:0]           dbg_data;
  logic [DATA_WIDTH-1:0]           word_done;

  logic grant_fetch;
  logic grant_dbg;
  logic accept;
  logic mem_en;
  logic fetch_valid;
  logic dbg_valid;
  logic capture;

  function automatic logic [ACTUAL_ADDRESS_WIDTH-1:0] fold(input logic [ADDRESS_WIDTH-1:0] a);
    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] sum;
    hi  = a[31:16];
    lo  = a[15:0];
    sum = hi + lo;
    return ACTUAL_ADDRESS_WIDTH'(sum);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (beat == 2'd3) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. Strobes are held low while rst is asserted, so a reset cycle never shows a grant or a pulse.
  always_comb begin
    grant_fetch = 1'b0;
    grant_dbg   = 1'b0;
    mem_en      = 1'b0;
    fetch_valid = 1'b0;
    dbg_valid   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          grant_fetch = bus.fetch_req_i & (~bus.dbg_req_i | last_dbg);
          grant_dbg   = bus.dbg_req_i & (~bus.fetch_req_i | ~last_dbg);
        end
        ISSUE:   mem_en = 1'b1;
        DONE: begin
          fetch_valid = ~owner_dbg;
          dbg_valid   = owner_dbg;
        end
        default: ;
      endcase
    end
  end

  assign accept = grant_fetch | grant_dbg;

  // Read data trails the strobe by one cycle, so beats 1..3 and DRAIN each capture the previous beat's byte.
  assign capture   = ((state == ISSUE) && (beat != 2'd0)) || (state == DRAIN);
  assign word_done = {word[DATA_WIDTH-9:0], bus.mem_rd_i};

  // Datapath: owner, address sequencing, and byte assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      owner_dbg  <= 1'b0;
      last_dbg   <= 1'b1;
      mem_addr   <= '0;
      word       <= '0;
      fetch_data <= '0;
      dbg_data   <= '0;
    end else begin
      if (accept) begin
        owner_dbg <= grant_dbg;
        last_dbg  <= grant_dbg;
        mem_addr  <= fold(grant_dbg ? bus.dbg_addr_i : bus.fetch_addr_i);
        beat      <= '0;
      end
      if (state == ISSUE) begin
        beat <= beat + 2'd1;
        if (beat != 2'd3) begin
          mem_addr <= mem_addr + 1'b1;
        end
      end
      if (capture) begin
        word <= word_done;
      end
      // Completed word is written straight to the owner's register at the end of DRAIN, so it is final in DONE.
      if (state == DRAIN) begin
        if (owner_dbg) begin
          dbg_data <= word_done;
        end else begin
          fetch_data <= word_done;
        end
      end
    end
  end

  assign bus.fetch_rdy_o   = grant_fetch;
  assign bus.dbg_rdy_o     = grant_dbg;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.dbg_valid_o   = dbg_valid;
  assign bus.fetch_data_o  = fetch_data;
  assign bus.dbg_data_o    = dbg_data;
  assign bus.mem_en_o      = mem_en;
  assign bus.mem_addr_o    = mem_addr;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl. A transaction-age reference model is compared against the DUT every cycle.
// Directed scenarios add literal expectations on top of that.
module tb_imem_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .ACTUAL_ADDRESS_WIDTH(16)
  ) bus ();

  imem_fetch_ctrl #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .ACTUAL_ADDRESS_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] rom [0:65535];
  always @(posedge clk) if (bus.mem_en_o) bus.mem_rd_i <= rom[bus.mem_addr_o];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: age = cycles since accept (-1 when no word is in flight)
  int          age = -1;
  bit          m_owner_dbg = 1'b0;
  bit          m_last_dbg = 1'b1;
  logic [15:0] m_base = '0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_fd = '0;
  logic [31:0] m_dd = '0;

  function automatic logic [15:0] fold(input logic [31:0] a);
    return 16'((a >> 16) + (a & 32'h0000FFFF));
  endfunction

  function automatic logic [31:0] word_at(input logic [15:0] b);
    return {rom[b], rom[16'(b + 16'd1)], rom[16'(b + 16'd2)], rom[16'(b + 16'd3)]};
  endfunction

  // Returns {debug grant, fetch grant} for the present cycle
  function automatic logic [1:0] pred_grant();
    if (rst || age >= 0) return 2'b00;
    if (bus.fetch_req_i && bus.dbg_req_i) return m_last_dbg ? 2'b01 : 2'b10;
    if (bus.fetch_req_i) return 2'b01;
    if (bus.dbg_req_i) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] g;
    g = pred_grant();
    if (rst) begin
      age = -1; m_last_dbg = 1'b1; m_addr = '0; m_fd = '0; m_dd = '0;
    end else begin
      if (age < 0) begin
        if (g != 2'b00) begin
          m_owner_dbg = g[1];
          m_last_dbg  = g[1];
          m_base      = fold(g[1] ? bus.dbg_addr_i : bus.fetch_addr_i);
          age         = 1;
        end
      end else if (age == 6) begin
        age = -1;
      end else begin
        age++;
      end
      if (age >= 1 && age <= 4) m_addr = 16'(m_base + 16'(age - 1));
      if (age == 6) begin
        if (m_owner_dbg) m_dd = word_at(m_base);
        else m_fd = word_at(m_base);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] g;
    if (chk_en) begin
      g = pred_grant();
      chk("fetch_rdy", 32'(bus.fetch_rdy_o), 32'(g[0]));
      chk("dbg_rdy", 32'(bus.dbg_rdy_o), 32'(g[1]));
      chk("rdy_exclusive", 32'(bus.fetch_rdy_o & bus.dbg_rdy_o), 32'd0);
      chk("fetch_valid", 32'(bus.fetch_valid_o), 32'(!rst && age == 6 && !m_owner_dbg));
      chk("dbg_valid", 32'(bus.dbg_valid_o), 32'(!rst && age == 6 && m_owner_dbg));
      chk("mem_en", 32'(bus.mem_en_o), 32'(!rst && age >= 1 && age <= 4));
      chk("mem_addr", 32'(bus.mem_addr_o), 32'(m_addr));
      chk("fetch_data", bus.fetch_data_o, m_fd);
      chk("dbg_data", bus.dbg_data_o, m_dd);
    end
  end

  logic [15:0] seen [4];
  int          nseen;

  task automatic wait_acc(input bit port, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port ? (bus.dbg_rdy_o && bus.dbg_req_i) : (bus.fetch_rdy_o && bus.fetch_req_i)) begin
        t = cyc;
        break;
      end
    end
    chk("accept_timeout", 32'(t < 0), 32'd0);
  endtask

  task automatic do_txn(input bit port, input logic [31:0] addr, output int t_acc, output int t_v);
    @(posedge clk); #1;
    if (port) begin bus.dbg_req_i = 1'b1; bus.dbg_addr_i = addr; end
    else begin bus.fetch_req_i = 1'b1; bus.fetch_addr_i = addr; end
    wait_acc(port, t_acc);
    @(posedge clk); #1;
    if (port) bus.dbg_req_i = 1'b0;
    else bus.fetch_req_i = 1'b0;
    nseen = 0;
    t_v = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_en_o && nseen < 4) begin
        seen[nseen] = bus.mem_addr_o;
        nseen++;
      end
      if (port ? bus.dbg_valid_o : bus.fetch_valid_o) begin
        t_v = cyc;
        break;
      end
    end
    chk("valid_timeout", 32'(t_v < 0), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          t_acc, t_v, r;
    int          order [3];
    int          n, nv, nd;
    int          acc [3];
    int          vt [3];
    logic [15:0] lit1 [4];
    logic [15:0] lit2 [4];
    logic [31:0] a2, snap;

    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[16'h0010] = 8'h13; rom[16'h0011] = 8'h05; rom[16'h0012] = 8'h10; rom[16'h0013] = 8'h00;
    rom[16'hFFFF] = 8'hAA; rom[16'h0000] = 8'hBB; rom[16'h0001] = 8'hCC; rom[16'h0002] = 8'hDD;
    lit1 = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    lit2 = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};

    bus.fetch_req_i = 1'b0; bus.fetch_addr_i = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_addr_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_fetch_data", bus.fetch_data_o, 32'd0);
    chk("reset_dbg_data", bus.dbg_data_o, 32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("reset_mem_en", 32'(bus.mem_en_o), 32'd0);

    // Single aligned fetch
    do_txn(1'b0, 32'h0000_0010, t_acc, t_v);
    chk("t1_nbeats", 32'(nseen), 32'd4);
    for (int k = 0; k < 4; k++) chk("t1_mem_addr", 32'(seen[k]), 32'(lit1[k]));
    chk("t1_latency", 32'(t_v - t_acc), 32'd6);
    chk("t1_data", bus.fetch_data_o, 32'h1305_1000);
    chk("t1_dbg_valid", 32'(bus.dbg_valid_o), 32'd0);

    // Fold and wrap on the debug port
    do_txn(1'b1, 32'h0001_FFFE, t_acc, t_v);
    chk("t2_nbeats", 32'(nseen), 32'd4);
    for (int k = 0; k < 4; k++) chk("t2_mem_addr", 32'(seen[k]), 32'(lit2[k]));
    chk("t2_latency", 32'(t_v - t_acc), 32'd6);
    chk("t2_data", bus.dbg_data_o, 32'hAABB_CCDD);
    chk("t2_fetch_data_kept", bus.fetch_data_o, 32'h1305_1000);

    // Both requesters held for three words: fetch, debug, fetch
    @(posedge clk); #1;
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = $urandom;
    bus.dbg_req_i = 1'b1; bus.dbg_addr_i = $urandom;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (bus.fetch_rdy_o) begin order[n] = 0; n++; end
      else if (bus.dbg_rdy_o) begin order[n] = 1; n++; end
    end
    @(posedge clk); #1;
    bus.fetch_req_i = 1'b0; bus.dbg_req_i = 1'b0;
    chk("t3_grants", 32'(n), 32'd3);
    chk("t3_order0", 32'(order[0]), 32'd0);
    chk("t3_order1", 32'(order[1]), 32'd1);
    chk("t3_order2", 32'(order[2]), 32'd0);
    repeat (10) @(posedge clk);

    // Back-to-back fetch with request held
    snap = m_dd;
    @(posedge clk); #1;
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = $urandom;
    n = 0; nv = 0;
    for (int i = 0; i < 60 && nv < 3; i++) begin
      @(negedge clk);
      if (bus.fetch_rdy_o && n < 3) begin acc[n] = cyc; n++; end
      if (bus.fetch_valid_o) begin vt[nv] = cyc; nv++; end
    end
    @(posedge clk); #1;
    bus.fetch_req_i = 1'b0;
    chk("t4_accepts", 32'(n), 32'd3);
    chk("t4_valids", 32'(nv), 32'd3);
    chk("t4_acc_gap0", 32'(acc[1] - acc[0]), 32'd7);
    chk("t4_acc_gap1", 32'(acc[2] - acc[1]), 32'd7);
    chk("t4_valid_gap0", 32'(vt[1] - vt[0]), 32'd7);
    chk("t4_valid_gap1", 32'(vt[2] - vt[1]), 32'd7);
    chk("t4_dbg_data_kept", bus.dbg_data_o, snap);
    repeat (8) @(posedge clk);

    // Reset in cycle T+3 of a fetch
    @(posedge clk); #1;
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = $urandom;
    wait_acc(1'b0, t_acc);
    @(posedge clk); #1 bus.fetch_req_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    r = cyc;
    chk("t5_fetch_rdy", 32'(bus.fetch_rdy_o), 32'd0);
    chk("t5_dbg_rdy", 32'(bus.dbg_rdy_o), 32'd0);
    chk("t5_fetch_valid", 32'(bus.fetch_valid_o), 32'd0);
    chk("t5_dbg_valid", 32'(bus.dbg_valid_o), 32'd0);
    chk("t5_fetch_data", bus.fetch_data_o, 32'd0);
    chk("t5_dbg_data", bus.dbg_data_o, 32'd0);
    chk("t5_mem_en", 32'(bus.mem_en_o), 32'd0);
    chk("t5_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    a2 = $urandom;
    do_txn(1'b0, a2, t_acc, t_v);
    chk("t5_immediate_accept", 32'(t_acc - r), 32'd1);
    chk("t5_latency", 32'(t_v - t_acc), 32'd6);
    chk("t5_data", bus.fetch_data_o, word_at(fold(a2)));

    // Debug request withdrawn while fetch is issuing
    @(posedge clk); #1;
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = $urandom;
    wait_acc(1'b0, t_acc);
    @(posedge clk); #1 bus.fetch_req_i = 1'b0;
    @(posedge clk); #1 bus.dbg_req_i = 1'b1;
    @(posedge clk); #1 bus.dbg_req_i = 1'b0;
    nd = 0; nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dbg_rdy_o || bus.dbg_valid_o) nd++;
      if (bus.fetch_valid_o) nv++;
    end
    chk("t6_no_dbg_activity", 32'(nd), 32'd0);
    chk("t6_fetch_served", 32'(nv), 32'd1);

    // Randomized traffic, including drops and occasional reset
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.fetch_req_i  = ($urandom % 3) != 0;
      bus.dbg_req_i    = ($urandom % 3) != 0;
      bus.fetch_addr_i = $urandom;
      bus.dbg_addr_i   = $urandom;
      rst              = ($urandom % 120) == 0;
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.fetch_req_i = 1'b0; bus.dbg_req_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
